// File: rtl/lsu_ctrl.sv
// Load/store sequencer: aligns and strobes store data, runs one valid/ready bus
// transaction per memory operation and extends load data for writeback.
module lsu_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  load_type,
  input  logic [2:0]  store_type,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        misalign_err,
  output logic        access_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rsp_data,
  input  logic        bus_rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  op_load;
  logic [2:0]  off;
  logic [15:0] wait_cnt;

  logic        access;
  logic        misaligned;
  logic [7:0]  strb;
  logic [63:0] shifted_wdata;
  logic [63:0] shifted_rsp;
  logic [63:0] load_result;

  assign access = req_valid & (mem_read | mem_write);
  assign stall  = ((state == IDLE) & access) | (state == REQ) | (state == WAIT);

  // Decode size/alignment of the incoming operation; a store wins over a load.
  always_comb begin
    misaligned    = 1'b0;
    strb          = 8'h00;
    shifted_wdata = wdata << {addr[2:0], 3'b000};
    if (mem_write) begin
      case (store_type)
        3'd4: strb = 8'h01 << addr[2:0];
        3'd5: begin
          strb       = 8'h03 << addr[2:0];
          misaligned = addr[0];
        end
        3'd6: begin
          strb       = 8'h0F << addr[2:0];
          misaligned = (addr[1:0] != 2'b00);
        end
        3'd7: begin
          strb       = 8'hFF;
          misaligned = (addr[2:0] != 3'b000);
        end
        default: strb = 8'h00;
      endcase
    end else begin
      case (load_type)
        3'd2, 3'd6: misaligned = addr[0];
        3'd3, 3'd7: misaligned = (addr[1:0] != 2'b00);
        3'd4:       misaligned = (addr[2:0] != 3'b000);
        default:    misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    shifted_rsp = bus_rsp_data >> {off, 3'b000};
    case (op_load)
      3'd1:    load_result = {{56{shifted_rsp[7]}},  shifted_rsp[7:0]};
      3'd2:    load_result = {{48{shifted_rsp[15]}}, shifted_rsp[15:0]};
      3'd3:    load_result = {{32{shifted_rsp[31]}}, shifted_rsp[31:0]};
      3'd4:    load_result = shifted_rsp;
      3'd5:    load_result = {56'b0, shifted_rsp[7:0]};
      3'd6:    load_result = {48'b0, shifted_rsp[15:0]};
      3'd7:    load_result = {32'b0, shifted_rsp[31:0]};
      default: load_result = 64'b0;
    endcase
  end

  // Sequencer; done is raised on the edge that enters DONE so it lasts one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      op_load       <= 3'd0;
      off           <= 3'd0;
      wait_cnt      <= 16'd0;
      done          <= 1'b0;
      rdata         <= 64'd0;
      misalign_err  <= 1'b0;
      access_err    <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_write <= 1'b0;
      bus_addr      <= 64'd0;
      bus_wdata     <= 64'd0;
      bus_wstrb     <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            op_load       <= load_type;
            off           <= addr[2:0];
            bus_addr      <= {addr[63:3], 3'b000};
            bus_req_write <= mem_write;
            bus_wstrb     <= mem_write ? strb : 8'h00;
            bus_wdata     <= mem_write ? shifted_wdata : 64'd0;
            if (misaligned) begin
              misalign_err <= 1'b1;
              access_err   <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              bus_req_valid <= 1'b1;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            wait_cnt      <= 16'd0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            if (!bus_req_write) begin
              rdata <= load_result;
            end
            access_err   <= bus_rsp_err;
            misalign_err <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else if ((TIMEOUT_CYCLES != 16'd0) && (wait_cnt == TIMEOUT_CYCLES - 16'd1)) begin
            access_err   <= 1'b1;
            misalign_err <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: table of operations with a reactive bus model
// and a scoreboard of expected completions, plus timeout and reset sequences.
module tb_lsu_ctrl;

  localparam int TMO = 8;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  load_type;
  logic [2:0]  store_type;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        stall;
  logic        done;
  logic [63:0] rdata;
  logic        misalign_err;
  logic        access_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic        bus_rsp_err;

  lsu_ctrl #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign_err(misalign_err), .access_err(access_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  lt;
    logic [2:0]  st;
    logic [63:0] a;
    logic [63:0] wd;
    int          rdy_dly;
    int          rsp_dly;
    logic [63:0] rsp;
    logic        rsp_err;
    logic [63:0] exp_baddr;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic        exp_mis;
    logic        exp_acc;
    logic        keep;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        acc;
    int          lat;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] last_rdata = 64'd0;
  exp_t        sb[$];
  vec_t        tbl[$];

  function automatic vec_t mk(logic wr, logic rd, logic [2:0] lt, logic [2:0] st,
                              logic [63:0] a, logic [63:0] wd, int rdy, int rspd,
                              logic [63:0] rsp, logic rerr, logic [63:0] ba,
                              logic [7:0] ws, logic [63:0] wdx, logic mis,
                              logic acc, logic keep, logic [63:0] rdx);
    vec_t v;
    v.wr = wr; v.rd = rd; v.lt = lt; v.st = st; v.a = a; v.wd = wd;
    v.rdy_dly = rdy; v.rsp_dly = rspd; v.rsp = rsp; v.rsp_err = rerr;
    v.exp_baddr = ba; v.exp_wstrb = ws; v.exp_wdata = wdx;
    v.exp_mis = mis; v.exp_acc = acc; v.keep = keep; v.exp_rdata = rdx;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    load_type = 3'd0; store_type = 3'd0; addr = 64'd0; wdata = 64'd0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_stall"}, {63'd0, stall}, 64'd0);
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_req_valid"}, {63'd0, bus_req_valid}, 64'd0);
  endtask

  // Drives one operation, plays the bus side and pops the scoreboard on done.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit   finished, in_wait, seen_req;
    int   req_c, wait_c;
    @(negedge clock);
    req_valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
    load_type = v.lt; store_type = v.st; addr = v.a; wdata = v.wd;
    #1 checkOutput("stall_accept", {63'd0, stall}, 64'd1);
    e.rdata = v.keep ? last_rdata : v.exp_rdata;
    e.mis   = v.exp_mis;
    e.acc   = v.exp_acc;
    e.lat   = v.exp_mis ? 1 : (v.rsp_dly < 0 ? 2 + v.rdy_dly + TMO : 3 + v.rdy_dly + v.rsp_dly);
    sb.push_back(e);
    finished = 0; in_wait = 0; seen_req = 0; req_c = 0; wait_c = 0;
    for (int c = 1; c <= 200 && !finished; c++) begin
      @(negedge clock);
      clearInputs();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
      #1;
      if (done) begin
        e = sb.pop_front();
        checkOutput("done_latency", 64'(c), 64'(e.lat));
        checkOutput("rdata", rdata, e.rdata);
        checkOutput("misalign_err", {63'd0, misalign_err}, {63'd0, e.mis});
        checkOutput("access_err", {63'd0, access_err}, {63'd0, e.acc});
        checkOutput("stall_in_done", {63'd0, stall}, 64'd0);
        checkOutput("bus_request_issued", {63'd0, seen_req}, {63'd0, ~v.exp_mis});
        last_rdata = e.rdata;
        finished = 1;
      end else begin
        checkOutput("stall_busy", {63'd0, stall}, 64'd1);
        if (bus_req_valid) begin
          seen_req = 1;
          checkOutput("bus_addr", bus_addr, v.exp_baddr);
          checkOutput("bus_req_write", {63'd0, bus_req_write}, {63'd0, v.wr});
          checkOutput("bus_wstrb", {56'd0, bus_wstrb}, {56'd0, v.exp_wstrb});
          checkOutput("bus_wdata", bus_wdata, v.exp_wdata);
          if (req_c >= v.rdy_dly) begin
            bus_req_ready = 1'b1;
            in_wait = 1;
          end
          req_c++;
        end else if (in_wait) begin
          if (v.rsp_dly >= 0 && wait_c == v.rsp_dly) begin
            bus_rsp_valid = 1'b1; bus_rsp_data = v.rsp; bus_rsp_err = v.rsp_err;
          end
          wait_c++;
        end
      end
    end
    if (!finished) begin
      tests++; fails++;
      $display("[TB] FAIL done_timeout: got no done within 200 cycles, expected done after %0d", e.lat);
      sb.delete();
    end
  endtask

  initial begin
    vec_t tv;
    clearInputs();
    reset = 1'b1; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    bus_rsp_data = 64'd0; bus_rsp_err = 1'b0;

    tbl.push_back(mk(0,1,3'd1,3'd0,64'h1003,0,0,0,64'h0000_0000_8000_0000,0,64'h1000,8'h00,64'h0,0,0,0,64'hFFFF_FFFF_FFFF_FF80));
    tbl.push_back(mk(1,0,3'd0,3'd5,64'h2006,64'hABCD,0,0,64'h0,0,64'h2000,8'hC0,64'hABCD_0000_0000_0000,0,0,1,64'h0));
    tbl.push_back(mk(0,1,3'd3,3'd0,64'h3002,0,0,0,64'h0,0,64'h0,8'h00,64'h0,1,0,1,64'h0));
    tbl.push_back(mk(0,1,3'd7,3'd0,64'h4004,0,4,5,64'h89AB_CDEF_0123_4567,0,64'h4000,8'h00,64'h0,0,0,0,64'h0000_0000_89AB_CDEF));
    tbl.push_back(mk(0,1,3'd2,3'd0,64'h6002,0,0,0,64'h0000_0000_8001_0000,0,64'h6000,8'h00,64'h0,0,0,0,64'hFFFF_FFFF_FFFF_8001));
    tbl.push_back(mk(0,1,3'd6,3'd0,64'h6006,0,1,2,64'hFFFE_0000_0000_0000,0,64'h6000,8'h00,64'h0,0,0,0,64'h0000_0000_0000_FFFE));
    tbl.push_back(mk(0,1,3'd4,3'd0,64'h7008,0,0,1,64'h0123_4567_89AB_CDEF,0,64'h7008,8'h00,64'h0,0,0,0,64'h0123_4567_89AB_CDEF));
    tbl.push_back(mk(1,0,3'd0,3'd7,64'h8000,64'h1122_3344_5566_7788,2,0,64'h0,0,64'h8000,8'hFF,64'h1122_3344_5566_7788,0,0,1,64'h0));
    tbl.push_back(mk(1,0,3'd0,3'd4,64'h8005,64'hFFFF_FFFF_FFFF_FFA5,0,0,64'h0,0,64'h8000,8'h20,64'hFFFF_A500_0000_0000,0,0,1,64'h0));
    tbl.push_back(mk(0,1,3'd5,3'd0,64'h9007,0,0,0,64'hF000_0000_0000_0000,0,64'h9000,8'h00,64'h0,0,0,0,64'h0000_0000_0000_00F0));
    tbl.push_back(mk(0,1,3'd3,3'd0,64'hA004,0,0,3,64'h7FFF_FFFF_0000_0000,1,64'hA000,8'h00,64'h0,0,1,0,64'h0000_0000_7FFF_FFFF));
    tbl.push_back(mk(1,0,3'd0,3'd6,64'hB001,64'h1,0,0,64'h0,0,64'h0,8'h00,64'h0,1,0,1,64'h0));
    tbl.push_back(mk(1,0,3'd0,3'd7,64'hC004,64'h1,0,0,64'h0,0,64'h0,8'h00,64'h0,1,0,1,64'h0));
    tbl.push_back(mk(1,1,3'd4,3'd6,64'hD004,64'hDEAD_BEEF,0,0,64'h5555,0,64'hD000,8'hF0,64'hDEAD_BEEF_0000_0000,0,0,1,64'h0));
    tbl.push_back(mk(0,1,3'd1,3'd0,64'hE001,0,0,0,64'h0000_0000_0000_7F00,0,64'hE000,8'h00,64'h0,0,0,0,64'h0000_0000_0000_007F));

    repeat (2) @(negedge clock);
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_rdata", rdata, 64'd0);
    checkOutput("reset_errs", {62'd0, misalign_err, access_err}, 64'd0);
    checkOutput("reset_bus_addr", bus_addr, 64'd0);
    checkOutput("reset_bus_wstrb", {56'd0, bus_wstrb}, 64'd0);
    reset = 1'b0;

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Timeout with no response, then a late response must be ignored.
    tv = mk(0,1,3'd4,3'd0,64'h5000,0,0,-1,64'h0,0,64'h5000,8'h00,64'h0,0,1,1,64'h0);
    applyStimulus(tv);
    @(negedge clock);
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF; bus_rsp_err = 1'b0;
    #1 checkIdleOutputs("late_rsp");
    @(negedge clock);
    bus_rsp_valid = 1'b0;
    #1 checkIdleOutputs("late_rsp_after");
    checkOutput("late_rsp_rdata", rdata, last_rdata);
    checkOutput("late_rsp_access_err", {63'd0, access_err}, 64'd1);

    // Reset in the middle of WAIT: no done, all outputs cleared, late response ignored.
    @(negedge clock);
    req_valid = 1'b1; mem_read = 1'b1; load_type = 3'd3; addr = 64'hE000;
    @(negedge clock);
    clearInputs();
    #1 checkOutput("mid_req_valid", {63'd0, bus_req_valid}, 64'd1);
    bus_req_ready = 1'b1;
    @(negedge clock);
    bus_req_ready = 1'b0;
    repeat (2) begin
      @(negedge clock);
      #1 checkOutput("mid_wait_stall", {63'd0, stall}, 64'd1);
    end
    reset = 1'b1;
    @(negedge clock);
    #1;
    checkIdleOutputs("mid_reset");
    checkOutput("mid_reset_rdata", rdata, 64'd0);
    checkOutput("mid_reset_errs", {62'd0, misalign_err, access_err}, 64'd0);
    checkOutput("mid_reset_bus_addr", bus_addr, 64'd0);
    checkOutput("mid_reset_bus_wdata", bus_wdata, 64'd0);
    reset = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'h1234; bus_rsp_err = 1'b1;
    last_rdata = 64'd0;
    @(negedge clock);
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    #1;
    checkIdleOutputs("post_reset_rsp");
    checkOutput("post_reset_rdata", rdata, 64'd0);
    applyStimulus(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
